bram_byte_reader: RTL and testbench

BRAM_BYTE_READER -- requirements
Module: bram_byte_reader

---
 rtl/bram_byte_reader_pkg.sv | 34 +++
 rtl/bram_byte_reader.sv | 168 ++++++++++++++++
 tb/tb_bram_byte_reader.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_byte_reader_pkg.sv
// -----------------------------------------------------------------------------
// zynq_system package
// Shared definitions for the BRAM byte reader: the controller state encoding,
// the number of byte lanes in a 32-bit BRAM word, and a lane-select helper.
// -----------------------------------------------------------------------------
package zynq_system;

  // Controller states of the BRAM byte reader.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_WAIT = 3'd2,
    ST_EMIT = 3'd3,
    ST_DONE = 3'd4
  } rd_state_t;

  // Byte lanes per 32-bit BRAM word.
  localparam int unsigned LANES_PER_WORD = 4;

  // Extract one byte from a 32-bit word, lane 0 being the least significant.
  function automatic logic [7:0] select_lane(input logic [31:0] word,
                                             input logic [1:0]  lane);
    logic [7:0] byte_v;
    case (lane)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = 8'h00;
    endcase
    return byte_v;
  endfunction

endpackage

// File: rtl/bram_byte_reader.sv
// -----------------------------------------------------------------------------
// bram_byte_reader
// Reads a burst of 32-bit words from a BRAM port (one-cycle read latency) and
// streams them out as bytes, little-endian, over a valid/ready interface.
// Each byte carries its full byte address (word address plus lane).
//
// Ports
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : single-cycle burst request (ignored unless idle)
//   start_waddr          : first word address of the burst
//   word_cnt             : number of words; zero completes immediately
//   busy                 : burst in progress
//   done                 : one-cycle completion pulse
//   bram_en, bram_addr   : BRAM read enable and word address
//   bram_dout            : BRAM read data, valid the cycle after bram_en
//   out_valid, out_ready : byte stream handshake
//   out_data, out_baddr  : byte value and its byte address
// -----------------------------------------------------------------------------
module bram_byte_reader
  import zynq_system::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int CNT_WIDTH  = 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-3:0] start_waddr,
  input  logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-3:0] bram_addr,
  input  logic [31:0]           bram_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic [ADDR_WIDTH-1:0] out_baddr
);

  localparam int WW = ADDR_WIDTH - 2;

  localparam logic [WW-1:0]        WADDR_ONE = {{(WW-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [1:0]           LAST_LANE = 2'(LANES_PER_WORD - 1);

  rd_state_t             state_r;
  logic [WW-1:0]         waddr_r;
  logic [CNT_WIDTH-1:0]  rem_r;
  logic [31:0]           holding_r;
  logic [1:0]            lane_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  bram_en_r;
  logic [WW-1:0]         bram_addr_r;
  logic                  out_valid_r;
  logic [7:0]            out_data_r;
  logic [ADDR_WIDTH-1:0] out_baddr_r;

  logic [1:0]            lane_nxt_s;
  logic [WW-1:0]         waddr_nxt_s;

  assign lane_nxt_s  = lane_r + 2'd1;
  // Word address wraps naturally at the width of the register.
  assign waddr_nxt_s = waddr_r + WADDR_ONE;

  // Burst controller: state, counters, holding register and all outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      waddr_r     <= {WW{1'b0}};
      rem_r       <= CNT_ZERO;
      holding_r   <= 32'h0000_0000;
      lane_r      <= 2'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      bram_en_r   <= 1'b0;
      bram_addr_r <= {WW{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= 8'h00;
      out_baddr_r <= {ADDR_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r    <= 1'b0;
          bram_en_r <= 1'b0;
          if (start) begin
            waddr_r <= start_waddr;
            rem_r   <= word_cnt;
            if (word_cnt == CNT_ZERO) begin
              // Empty burst: report completion without touching the BRAM.
              state_r <= ST_DONE;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
            end else begin
              state_r     <= ST_READ;
              busy_r      <= 1'b1;
              bram_en_r   <= 1'b1;
              bram_addr_r <= start_waddr;
            end
          end
        end

        ST_READ: begin
          // The enable was raised on entry; this is its only cycle.
          bram_en_r <= 1'b0;
          state_r   <= ST_WAIT;
        end

        ST_WAIT: begin
          // Read data is valid now; present lane 0 straight away.
          holding_r   <= bram_dout;
          lane_r      <= 2'd0;
          out_valid_r <= 1'b1;
          out_data_r  <= select_lane(bram_dout, 2'd0);
          out_baddr_r <= {waddr_r, 2'd0};
          state_r     <= ST_EMIT;
        end

        ST_EMIT: begin
          if (out_valid_r && out_ready) begin
            if (lane_r == LAST_LANE) begin
              out_valid_r <= 1'b0;
              rem_r       <= rem_r - CNT_ONE;
              waddr_r     <= waddr_nxt_s;
              if (rem_r > CNT_ONE) begin
                state_r     <= ST_READ;
                bram_en_r   <= 1'b1;
                bram_addr_r <= waddr_nxt_s;
              end else begin
                state_r <= ST_DONE;
                done_r  <= 1'b1;
                busy_r  <= 1'b0;
              end
            end else begin
              lane_r      <= lane_nxt_s;
              out_data_r  <= select_lane(holding_r, lane_nxt_s);
              out_baddr_r <= {waddr_r, lane_nxt_s};
            end
          end
        end

        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          bram_en_r   <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign bram_en   = bram_en_r;
  assign bram_addr = bram_addr_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_baddr = out_baddr_r;

endmodule

// File: tb/tb_bram_byte_reader.sv
// -----------------------------------------------------------------------------
// tb_bram_byte_reader
// Self-checking bench for bram_byte_reader. A BRAM model with one-cycle read
// latency feeds the DUT; a negedge monitor logs transfers, enables, valid
// rises and done pulses; each test task compares the log with a reference
// stream computed from the memory contents and the burst parameters.
// -----------------------------------------------------------------------------
module tb_bram_byte_reader;

  localparam int AW = 15;
  localparam int CW = 13;
  localparam int WW = AW - 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [WW-1:0] start_waddr = '0;
  logic [CW-1:0] word_cnt = '0;
  logic          busy, done, bram_en, out_valid;
  logic [WW-1:0] bram_addr;
  logic [31:0]   bram_dout = 32'h0;
  logic          out_ready = 1'b0;
  logic [7:0]    out_data;
  logic [AW-1:0] out_baddr;

  bram_byte_reader #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_waddr(start_waddr),
    .word_cnt(word_cnt), .busy(busy), .done(done), .bram_en(bram_en),
    .bram_addr(bram_addr), .bram_dout(bram_dout), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_baddr(out_baddr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // BRAM model: registered read, data valid the cycle after the enable.
  logic [31:0] mem [0:(1<<WW)-1];
  always @(posedge clk) if (bram_en) bram_dout <= mem[bram_addr];

  // Monitor log (written only here, read by the tests through baselines).
  int            cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [7:0]    obs_data[$];
  logic [AW-1:0] obs_baddr[$];
  logic [WW-1:0] obs_en_addr[$];
  int            en_cyc[$];
  int            vrise_cyc[$];
  int            done_cyc[$];
  int            start_cyc = 0;
  int            stall_err = 0;
  int            done_busy_err = 0;
  logic          prev_stall = 1'b0, prev_valid = 1'b0;
  logic [7:0]    prev_d = 8'h00;
  logic [AW-1:0] prev_b = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (start) start_cyc = cyc;
      if (bram_en) begin
        obs_en_addr.push_back(bram_addr);
        en_cyc.push_back(cyc);
      end
      if (out_valid && !prev_valid) vrise_cyc.push_back(cyc);
      if (out_valid && out_ready) begin
        obs_data.push_back(out_data);
        obs_baddr.push_back(out_baddr);
      end
      if (done) begin
        done_cyc.push_back(cyc);
        if (busy) done_busy_err++;
      end
      if (prev_stall && (!out_valid || out_data !== prev_d || out_baddr !== prev_b))
        stall_err++;
      prev_stall = out_valid && !out_ready;
      prev_valid = out_valid;
      prev_d     = out_data;
      prev_b     = out_baddr;
    end
  end

  // Reference stream and log baselines for the current burst.
  logic [7:0]    exp_d[$];
  logic [AW-1:0] exp_b[$];
  logic [WW-1:0] exp_en[$];
  int b_obs, b_en, b_vr, b_done, b_stall;
  bit timed_out;

  // Expected bytes: consecutive words from sa (wrapping), lanes 0..3 each.
  task automatic build_exp(input logic [WW-1:0] sa, input int cnt);
    logic [WW-1:0] a;
    logic [31:0]   w;
    exp_d.delete(); exp_b.delete(); exp_en.delete();
    for (int k = 0; k < cnt; k++) begin
      a = sa + WW'(k);
      w = mem[a];
      exp_en.push_back(a);
      for (int l = 0; l < 4; l++) begin
        exp_d.push_back(8'(w >> (8 * l)));
        exp_b.push_back({a, 2'(l)});
      end
    end
  endtask

  function automatic int stream_bad();
    int n, bad;
    n = obs_data.size() - b_obs;
    bad = (n > exp_d.size()) ? n - exp_d.size() : exp_d.size() - n;
    for (int i = 0; i < n && i < exp_d.size(); i++)
      if (obs_data[b_obs+i] !== exp_d[i] || obs_baddr[b_obs+i] !== exp_b[i]) bad++;
    return bad;
  endfunction

  function automatic int en_bad();
    int n, bad;
    n = obs_en_addr.size() - b_en;
    bad = (n > exp_en.size()) ? n - exp_en.size() : exp_en.size() - n;
    for (int i = 0; i < n && i < exp_en.size(); i++)
      if (obs_en_addr[b_en+i] !== exp_en[i]) bad++;
    return bad;
  endfunction

  task automatic mark_baselines();
    b_obs = obs_data.size(); b_en = obs_en_addr.size();
    b_vr = vrise_cyc.size(); b_done = done_cyc.size(); b_stall = stall_err;
  endtask

  // Pulse start, then wait for done; optionally randomize out_ready and
  // inject a second start 'inject' cycles into the burst.
  task automatic run_burst(input logic [WW-1:0] sa, input int cnt,
                           input bit rnd, input int inject);
    int budget;
    build_exp(sa, cnt);
    mark_baselines();
    budget = 100 + cnt * 60;
    @(posedge clk); #1;
    start = 1'b1; start_waddr = sa; word_cnt = CW'(cnt);
    @(posedge clk); #1;
    start = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (done_cyc.size() > b_done) begin
        timed_out = 1'b0;
        break;
      end
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      start = (i == inject);
      if (i == inject) begin
        start_waddr = ~sa;
        word_cnt = CW'(cnt + 5);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    tests++;
    if (timed_out) begin
      fails++;
      $display("FAIL done_timeout: no done within %0d cycles (sa=%h cnt=%0d)", budget, sa, cnt);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({busy, done, bram_en, bram_addr, out_valid, out_data, out_baddr} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: busy=%b done=%b en=%b addr=%h valid=%b data=%h baddr=%h, want all 0",
               busy, done, bram_en, bram_addr, out_valid, out_data, out_baddr);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    mem[13'h010] = 32'h4433_2211;
    mem[13'h011] = 32'h8877_6655;
    out_ready = 1'b1;
    run_burst(13'h010, 2, 1'b0, -1);
    tests++;
    if (stream_bad() != 0) begin
      fails++;
      $display("FAIL basic_stream: %0d bytes, %0d bad, want 8 bytes 0 bad", obs_data.size() - b_obs, stream_bad());
    end
    tests++;
    if (obs_data.size() - b_obs < 8 || obs_data[b_obs] !== 8'h11 || obs_baddr[b_obs] !== 15'h040 ||
        obs_data[b_obs+7] !== 8'h88 || obs_baddr[b_obs+7] !== 15'h047) begin
      fails++;
      $display("FAIL basic_ends: first/last byte or address wrong, want 11@040 and 88@047");
    end
    tests++;
    if (en_bad() != 0) begin
      fails++;
      $display("FAIL basic_bram_addr: %0d bad enables, want addresses 010,011", en_bad());
    end
    tests++;
    if (en_cyc.size() <= b_en || vrise_cyc.size() <= b_vr || done_cyc.size() <= b_done ||
        en_cyc[b_en] != start_cyc + 1 || vrise_cyc[b_vr] != start_cyc + 3 ||
        done_cyc[b_done] != start_cyc + 13) begin
      fails++;
      $display("FAIL basic_latency: start=%0d, want en at +1, valid at +3, done at +13", start_cyc);
    end
    tests++;
    if (done_cyc.size() - b_done != 1 || done_busy_err != 0) begin
      fails++;
      $display("FAIL basic_done: %0d pulses, %0d with busy high, want 1 and 0",
               done_cyc.size() - b_done, done_busy_err);
    end
  endtask

  task automatic test_zero_count();
    run_burst(13'h0123, 0, 1'b0, -1);
    tests++;
    if (obs_en_addr.size() != b_en || vrise_cyc.size() != b_vr) begin
      fails++;
      $display("FAIL zero_no_activity: %0d enables %0d valid rises, want 0 and 0",
               obs_en_addr.size() - b_en, vrise_cyc.size() - b_vr);
    end
    tests++;
    if (done_cyc.size() - b_done != 1 || done_cyc[b_done] != start_cyc + 1) begin
      fails++;
      $display("FAIL zero_done: %0d pulses, want 1 at start+1 (start=%0d)", done_cyc.size() - b_done, start_cyc);
    end
  endtask

  task automatic test_wrap();
    mem[13'h1FFF] = $urandom;
    mem[13'h0000] = $urandom;
    run_burst(13'h1FFF, 2, 1'b0, -1);
    tests++;
    if (en_bad() != 0 || obs_en_addr.size() - b_en != 2 || obs_en_addr[b_en+1] !== 13'h0000) begin
      fails++;
      $display("FAIL wrap_bram_addr: %0d bad enables, want 1fff then 0000", en_bad());
    end
    tests++;
    if (stream_bad() != 0 || obs_baddr[b_obs] !== 15'h7FFC || obs_baddr[b_obs+4] !== 15'h0000) begin
      fails++;
      $display("FAIL wrap_stream: %0d bad bytes, want baddr 7ffc..7fff then 0000..0003", stream_bad());
    end
  endtask

  task automatic test_random_ready();
    logic [WW-1:0] sa;
    sa = WW'($urandom);
    for (int k = 0; k < 3; k++) mem[sa + WW'(k)] = $urandom;
    run_burst(sa, 3, 1'b1, -1);
    tests++;
    if (stream_bad() != 0) begin
      fails++;
      $display("FAIL stall_stream: %0d bytes, %0d bad, want 12 bytes 0 bad", obs_data.size() - b_obs, stream_bad());
    end
    tests++;
    if (stall_err != b_stall) begin
      fails++;
      $display("FAIL stall_stable: %0d unstable stalled cycles, want 0", stall_err - b_stall);
    end
  endtask

  task automatic test_start_while_busy();
    logic [WW-1:0] sa;
    sa = WW'($urandom);
    for (int k = 0; k < 2; k++) mem[sa + WW'(k)] = $urandom;
    run_burst(sa, 2, 1'b0, 3);
    tests++;
    if (stream_bad() != 0 || en_bad() != 0) begin
      fails++;
      $display("FAIL busy_start_ignored: %0d bad bytes, %0d bad enables, want 0 and 0", stream_bad(), en_bad());
    end
    tests++;
    if (done_cyc.size() - b_done != 1) begin
      fails++;
      $display("FAIL busy_start_done: %0d done pulses, want 1", done_cyc.size() - b_done);
    end
  endtask

  task automatic test_reset_mid_emit();
    int w;
    out_ready = 1'b0;
    mark_baselines();
    @(posedge clk); #1;
    start = 1'b1; start_waddr = 13'h0222; word_cnt = 13'd2;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (!out_valid && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (w >= 20 || {busy, done, bram_en, bram_addr, out_valid, out_data, out_baddr} !== '0) begin
      fails++;
      $display("FAIL midreset_outputs: wait=%0d busy=%b valid=%b data=%h baddr=%h, want all 0 after reset",
               w, busy, out_valid, out_data, out_baddr);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (done_cyc.size() != b_done || busy !== 1'b0) begin
      fails++;
      $display("FAIL midreset_no_done: %0d done pulses busy=%b, want 0 and 0", done_cyc.size() - b_done, busy);
    end
    out_ready = 1'b1;
    mem[13'h0300] = $urandom;
    run_burst(13'h0300, 1, 1'b0, -1);
    tests++;
    if (stream_bad() != 0 || done_cyc.size() - b_done != 1) begin
      fails++;
      $display("FAIL midreset_restart: %0d bad bytes, %0d done pulses, want 0 and 1", stream_bad(), done_cyc.size() - b_done);
    end
  endtask

  task automatic test_random_bursts();
    logic [WW-1:0] sa;
    int cnt;
    for (int r = 0; r < 4; r++) begin
      sa  = WW'($urandom);
      cnt = $urandom_range(1, 3);
      for (int k = 0; k < cnt; k++) mem[sa + WW'(k)] = $urandom;
      run_burst(sa, cnt, 1'b1, -1);
      tests++;
      if (stream_bad() != 0 || en_bad() != 0 || done_cyc.size() - b_done != 1 || stall_err != b_stall) begin
        fails++;
        $display("FAIL random_burst_%0d: sa=%h cnt=%0d bad bytes=%0d bad enables=%0d dones=%0d stalls=%0d",
                 r, sa, cnt, stream_bad(), en_bad(), done_cyc.size() - b_done, stall_err - b_stall);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << WW); i++) mem[i] = 32'h0;
    test_reset();
    test_basic();
    test_zero_count();
    test_wrap();
    test_random_ready();
    test_start_while_busy();
    test_reset_mid_emit();
    test_random_bursts();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
